// File: rtl/stream_hdr_dispatch_pkg.sv
// ============================================================================
// Module  : stream_hdr_pkg
// Brief   : Shared parser states, default head words and head-compare mask
//           for stream_hdr_dispatch.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_hdr_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_IHEAD2  = 3'd1,
    S_CFG     = 3'd2,
    S_DHEAD2  = 3'd3,
    S_PAYLOAD = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  localparam logic [63:0] DEF_INST_HEAD = 64'hefef_123a_bbee_ff22;
  localparam logic [63:0] DEF_DATA_HEAD = 64'hefef_6543_dada_ff00;

  // The low byte of a data head carries the channel id and is excluded from the match.
  localparam int          CH_ID_BITS    = 8;
  localparam logic [63:0] DEF_HEAD_MASK = 64'hffff_ffff_ffff_ff00;

endpackage

`default_nettype wire

// File: rtl/stream_hdr_dispatch_payload_router.sv
// ============================================================================
// Module  : payload_router
// Brief   : Routes FIFO word-available to the active payload channel and
//           selects that channel's read strobe as the FIFO pop.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module payload_router #(
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = 2
) (
  input  logic               i_en,
  input  logic [CH_BITS-1:0] i_ch,
  input  logic               i_empty_n,
  input  logic [NUM_CH-1:0]  i_ds_read,
  output logic [NUM_CH-1:0]  o_ds_empty_n,
  output logic               o_pop
);

  always_comb begin
    o_ds_empty_n = '0;
    o_pop        = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_en && (i_ch == CH_BITS'(i))) begin
        o_ds_empty_n[i] = i_empty_n;
        o_pop           = i_empty_n & i_ds_read[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/stream_hdr_dispatch.sv
// ============================================================================
// Module  : stream_hdr_dispatch
// Brief   : Parses instruction packets into config registers and routes data
//           packet payloads to one of NUM_CH downstream channels.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_hdr_dispatch
  import stream_hdr_pkg::*;
#(
  parameter int               TBITS     = 64,
  parameter int               NUM_CFG   = 3,
  parameter int               NUM_CH    = 4,
  parameter int               CH_BITS   = 2,
  parameter int               CNT_BITS  = 16,
  parameter logic [TBITS-1:0] INST_HEAD = TBITS'(DEF_INST_HEAD),
  parameter logic [TBITS-1:0] DATA_HEAD = TBITS'(DEF_DATA_HEAD)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TBITS-1:0]         fifo_data_din,
  input  logic                     fifo_last_din,
  input  logic                     fifo_empty_n_din,
  output logic                     fifo_read_dout,
  output logic [NUM_CFG*TBITS-1:0] cfg_words,
  output logic                     start_pulse,
  output logic [TBITS-1:0]         ds_data,
  output logic                     ds_last,
  output logic [NUM_CH-1:0]        ds_empty_n,
  input  logic [NUM_CH-1:0]        ds_read,
  output logic [CH_BITS-1:0]       ds_ch,
  output logic [NUM_CH-1:0]        payload_done,
  output logic [CNT_BITS-1:0]      pkt_cnt,
  output logic                     busy,
  output logic                     hdr_err,
  output logic                     cfg_err
);

  localparam int                      c_IDX_BITS  = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam logic [c_IDX_BITS-1:0]   c_IDX_LAST  = c_IDX_BITS'(NUM_CFG - 1);
  localparam logic [TBITS-1:0]        c_HEAD_MASK = ~TBITS'({CH_ID_BITS{1'b1}});

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CH_ID_BITS-1:0]   r_ch_tmp;
  logic [c_IDX_BITS-1:0]   r_idx;
  logic [TBITS-1:0]        r_shadow [NUM_CFG];
  logic [NUM_CFG*TBITS-1:0] r_cfg_words;
  logic                    r_start;
  logic                    r_hdr_err;
  logic                    r_cfg_err;
  logic [NUM_CH-1:0]       r_done;
  logic [CH_BITS-1:0]      r_ds_ch;
  logic [CNT_BITS-1:0]     r_pkt_cnt;

  logic w_pop;
  logic w_is_inst;
  logic w_is_data;
  logic w_ch_ok;
  logic w_idx_last;
  logic w_route_en;
  logic w_route_pop;
  logic w_hdr_err_ev;
  logic w_cfg_err_ev;
  logic w_cfg_wr;
  logic w_commit;
  logic w_latch_ch;
  logic w_pay_start;
  logic w_pay_pop;

  assign w_is_inst  = (fifo_data_din == INST_HEAD);
  assign w_is_data  = ((fifo_data_din & c_HEAD_MASK) == (DATA_HEAD & c_HEAD_MASK));
  assign w_ch_ok    = (32'(r_ch_tmp) < 32'(NUM_CH));
  assign w_idx_last = (r_idx == c_IDX_LAST);
  assign w_route_en = (r_state == S_PAYLOAD) && !reset;
  assign w_pop      = fifo_read_dout & fifo_empty_n_din;

  payload_router #(
    .NUM_CH  (NUM_CH),
    .CH_BITS (CH_BITS)
  ) u_payload_router (
    .i_en         (w_route_en),
    .i_ch         (r_ds_ch),
    .i_empty_n    (fifo_empty_n_din),
    .i_ds_read    (ds_read),
    .o_ds_empty_n (ds_empty_n),
    .o_pop        (w_route_pop)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_pop) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_inst && !fifo_last_din)      w_state_nxt = S_IHEAD2;
          else if (w_is_data && !fifo_last_din) w_state_nxt = S_DHEAD2;
          else if (!fifo_last_din)              w_state_nxt = S_DRAIN;
        end
        S_IHEAD2: begin
          if (w_is_inst && fifo_last_din) w_state_nxt = S_CFG;
          else if (fifo_last_din)         w_state_nxt = S_IDLE;
          else                            w_state_nxt = S_DRAIN;
        end
        S_CFG: begin
          if (fifo_last_din)   w_state_nxt = S_IDLE;
          else if (w_idx_last) w_state_nxt = S_DRAIN;
        end
        S_DHEAD2: begin
          if (w_is_data && fifo_last_din) w_state_nxt = w_ch_ok ? S_PAYLOAD : S_DRAIN;
          else if (fifo_last_din)         w_state_nxt = S_IDLE;
          else                            w_state_nxt = S_DRAIN;
        end
        S_PAYLOAD, S_DRAIN: begin
          if (fifo_last_din) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Outside the payload phase every available word is popped immediately.
  always_comb begin
    fifo_read_dout = 1'b0;
    w_hdr_err_ev   = 1'b0;
    w_cfg_err_ev   = 1'b0;
    w_cfg_wr       = 1'b0;
    w_commit       = 1'b0;
    w_latch_ch     = 1'b0;
    w_pay_start    = 1'b0;
    w_pay_pop      = 1'b0;
    if (!reset) begin
      fifo_read_dout = (r_state == S_PAYLOAD) ? w_route_pop : fifo_empty_n_din;
    end
    case (r_state)
      S_IDLE: begin
        w_latch_ch   = w_pop && w_is_data && !fifo_last_din;
        w_hdr_err_ev = w_pop && !((w_is_inst || w_is_data) && !fifo_last_din);
      end
      S_IHEAD2: begin
        w_hdr_err_ev = w_pop && !(w_is_inst && fifo_last_din);
      end
      S_CFG: begin
        w_cfg_wr     = w_pop;
        w_commit     = w_pop && w_idx_last && fifo_last_din;
        w_cfg_err_ev = w_pop && (w_idx_last ^ fifo_last_din);
      end
      S_DHEAD2: begin
        w_pay_start  = w_pop && w_is_data && fifo_last_din && w_ch_ok;
        w_hdr_err_ev = w_pop && !(w_is_data && fifo_last_din && w_ch_ok);
      end
      S_PAYLOAD: begin
        w_pay_pop = w_pop;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ch_tmp    <= '0;
      r_idx       <= '0;
      r_cfg_words <= '0;
      r_start     <= 1'b0;
      r_hdr_err   <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_done      <= '0;
      r_ds_ch     <= '0;
      r_pkt_cnt   <= '0;
      for (int k = 0; k < NUM_CFG; k++) r_shadow[k] <= '0;
    end else begin
      r_start   <= w_commit;
      r_hdr_err <= w_hdr_err_ev;
      r_cfg_err <= w_cfg_err_ev;
      for (int i = 0; i < NUM_CH; i++) begin
        r_done[i] <= w_pay_pop && fifo_last_din && (r_ds_ch == CH_BITS'(i));
      end

      if (w_latch_ch) r_ch_tmp <= fifo_data_din[CH_ID_BITS-1:0];

      if (w_cfg_wr) begin
        r_shadow[r_idx] <= fifo_data_din;
        r_idx           <= r_idx + 1'b1;
      end else if (r_state != S_CFG) begin
        r_idx <= '0;
      end

      // The final config word goes straight from the FIFO into the committed set.
      if (w_commit) begin
        for (int k = 0; k < NUM_CFG - 1; k++) r_cfg_words[k*TBITS +: TBITS] <= r_shadow[k];
        r_cfg_words[(NUM_CFG-1)*TBITS +: TBITS] <= fifo_data_din;
      end

      if (w_pay_start) begin
        r_ds_ch   <= r_ch_tmp[CH_BITS-1:0];
        r_pkt_cnt <= '0;
      end else if (w_pay_pop && (r_pkt_cnt != '1)) begin
        r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end
    end
  end

  assign cfg_words    = r_cfg_words;
  assign start_pulse  = r_start;
  assign ds_data      = fifo_data_din;
  assign ds_last      = fifo_last_din;
  assign ds_ch        = r_ds_ch;
  assign payload_done = r_done;
  assign pkt_cnt      = r_pkt_cnt;
  assign busy         = (r_state != S_IDLE);
  assign hdr_err      = r_hdr_err;
  assign cfg_err      = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_stream_hdr_dispatch.sv
// ============================================================================
// Module  : tb_stream_hdr_dispatch
// Brief   : Directed self-checking bench for stream_hdr_dispatch.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_hdr_dispatch;

  localparam int          TBITS    = 64;
  localparam int          NUM_CFG  = 3;
  localparam int          NUM_CH   = 4;
  localparam int          CH_BITS  = 2;
  localparam int          CNT_BITS = 16;
  localparam logic [63:0] IH       = 64'hefef_123a_bbee_ff22;
  localparam logic [63:0] DH       = 64'hefef_6543_dada_ff00;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [TBITS-1:0]         fifo_data_din;
  logic                     fifo_last_din;
  logic                     fifo_empty_n_din;
  logic                     fifo_read_dout;
  logic [NUM_CFG*TBITS-1:0] cfg_words;
  logic                     start_pulse;
  logic [TBITS-1:0]         ds_data;
  logic                     ds_last;
  logic [NUM_CH-1:0]        ds_empty_n;
  logic [NUM_CH-1:0]        ds_read;
  logic [CH_BITS-1:0]       ds_ch;
  logic [NUM_CH-1:0]        payload_done;
  logic [CNT_BITS-1:0]      pkt_cnt;
  logic                     busy;
  logic                     hdr_err;
  logic                     cfg_err;

  stream_hdr_dispatch #(
    .TBITS(TBITS), .NUM_CFG(NUM_CFG), .NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk(clk), .reset(reset),
    .fifo_data_din(fifo_data_din), .fifo_last_din(fifo_last_din),
    .fifo_empty_n_din(fifo_empty_n_din), .fifo_read_dout(fifo_read_dout),
    .cfg_words(cfg_words), .start_pulse(start_pulse),
    .ds_data(ds_data), .ds_last(ds_last), .ds_empty_n(ds_empty_n), .ds_read(ds_read),
    .ds_ch(ds_ch), .payload_done(payload_done), .pkt_cnt(pkt_cnt),
    .busy(busy), .hdr_err(hdr_err), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [64:0] q[$];
  logic [64:0] exp_q[$];
  int n_pop, n_pay, n_start, n_hdr, n_cfgerr, n_order;
  int n_done [NUM_CH];
  int n_en   [NUM_CH];
  int          rd_mode;
  logic [1:0]  rd_ch;
  logic [3:0]  rd_val;
  logic        prev_en;
  logic [15:0] last_cnt;
  int          pops_before;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    n_pop = 0; n_pay = 0; n_start = 0; n_hdr = 0; n_cfgerr = 0; n_order = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      n_done[i] = 0;
      n_en[i]   = 0;
    end
  endtask

  task automatic push(input logic [63:0] d, input logic l);
    q.push_back({l, d});
  endtask

  task automatic push_pay(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      q.push_back({(i == n - 1), base + 64'(i)});
      exp_q.push_back({(i == n - 1), base + 64'(i)});
    end
  endtask

  // One clock: drive FIFO head and consumer strobes on the falling edge, observe 1 ns later.
  task automatic cycle();
    @(negedge clk);
    if (q.size() != 0) begin
      fifo_data_din    = q[0][63:0];
      fifo_last_din    = q[0][64];
      fifo_empty_n_din = 1'b1;
    end else begin
      fifo_data_din    = '0;
      fifo_last_din    = 1'b0;
      fifo_empty_n_din = 1'b0;
    end
    if (rd_mode == 0) begin
      ds_read        = '0;
      ds_read[rd_ch] = prev_en;
    end else begin
      ds_read = rd_val;
    end
    #1;
    prev_en  = ds_empty_n[rd_ch];
    last_cnt = pkt_cnt;
    if (start_pulse) n_start++;
    if (hdr_err)     n_hdr++;
    if (cfg_err)     n_cfgerr++;
    for (int i = 0; i < NUM_CH; i++) begin
      if (payload_done[i]) n_done[i]++;
      if (ds_empty_n[i])   n_en[i]++;
    end
    if (fifo_read_dout && fifo_empty_n_din) begin
      n_pop++;
      if (ds_empty_n != '0) begin
        n_pay++;
        if (exp_q.size() == 0) n_order++;
        else begin
          if ({ds_last, ds_data} !== exp_q[0]) n_order++;
          void'(exp_q.pop_front());
        end
      end
      void'(q.pop_front());
    end
  endtask

  task automatic run_drain(input string tag, input int max);
    int k = 0;
    while (q.size() != 0 && k < max) begin
      cycle();
      k++;
    end
    check(tag, 256'(q.size()), 256'(0));
    repeat (3) cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic send_inst(input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2);
    push(IH, 1'b0); push(IH, 1'b1);
    push(w0, 1'b0); push(w1, 1'b0); push(w2, 1'b1);
  endtask

  initial begin
    reset            = 1'b1;
    fifo_data_din    = IH;
    fifo_last_din    = 1'b0;
    fifo_empty_n_din = 1'b1;
    ds_read          = '1;
    rd_mode          = 0;
    rd_ch            = 2'd1;
    rd_val           = '0;
    prev_en          = 1'b0;
    clear_mon();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_pop", 256'(fifo_read_dout), 256'(0));
    @(negedge clk);
    reset = 1'b0; fifo_empty_n_din = 1'b0; ds_read = '0;
    #1;
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_cfg", 256'(cfg_words), 256'(0));
    check("rst_en", 256'({ds_empty_n, payload_done}), 256'(0));
    check("rst_cnt_ch", 256'({pkt_cnt, ds_ch}), 256'(0));
    check("rst_pulses", 256'({start_pulse, hdr_err, cfg_err}), 256'(0));

    // Test 1: valid instruction packet
    clear_mon();
    send_inst(64'hffff_0000_0000_0000, 64'heeee_eeee_eeee_eeee, 64'heeee_eeee_eeee_eeee);
    run_drain("t1_bound", 50);
    check("t1_cfg", 256'(cfg_words),
          256'({64'heeee_eeee_eeee_eeee, 64'heeee_eeee_eeee_eeee, 64'hffff_0000_0000_0000}));
    check("t1_start", 256'(n_start), 256'(1));
    check("t1_pops", 256'(n_pop), 256'(5));
    check("t1_busy", 256'(busy), 256'(0));
    check("t1_errs", 256'(n_hdr + n_cfgerr), 256'(0));

    // Bad heads from idle: unknown word with last; instruction head followed by a mismatch
    clear_mon();
    push(64'h0000_0000_0000_0123, 1'b1);
    push(IH, 1'b0); push(64'h5555_5555_5555_5555, 1'b1);
    run_drain("hb_bound", 50);
    check("hb_hdr", 256'(n_hdr), 256'(2));
    check("hb_pops", 256'(n_pop), 256'(3));
    check("hb_busy", 256'(busy), 256'(0));

    // Test 2: data packet to channel 1, 264 words, consumer one cycle late
    clear_mon();
    rd_mode = 0; rd_ch = 2'd1; prev_en = 1'b0;
    push({DH[63:8], 8'h01}, 1'b0); push({DH[63:8], 8'h01}, 1'b1);
    push_pay(264, 64'h1000_0000_0000_0000);
    run_drain("t2_bound", 2000);
    check("t2_pay", 256'(n_pay), 256'(264));
    check("t2_order", 256'(n_order), 256'(0));
    check("t2_exp_left", 256'(exp_q.size()), 256'(0));
    check("t2_other_en", 256'(n_en[0] + n_en[2] + n_en[3]), 256'(0));
    check("t2_done1", 256'(n_done[1]), 256'(1));
    check("t2_done_other", 256'(n_done[0] + n_done[2] + n_done[3]), 256'(0));
    check("t2_cnt", 256'(pkt_cnt), 256'(264));
    check("t2_busy", 256'(busy), 256'(0));

    // Test 3: channel 2, stall 20 cycles after 10 words with a stray read on channel 0
    clear_mon();
    rd_mode = 0; rd_ch = 2'd2; prev_en = 1'b0;
    push({DH[63:8], 8'h02}, 1'b0); push({DH[63:8], 8'h02}, 1'b1);
    push_pay(40, 64'h2000_0000_0000_0000);
    for (int k = 0; k < 200 && n_pop < 12; k++) cycle();
    check("t3_pre_pops", 256'(n_pop), 256'(12));
    check("t3_ch", 256'(ds_ch), 256'(2));
    rd_mode = 1; rd_val = 4'b0001;
    pops_before = n_pop;
    repeat (20) cycle();
    check("t3_stall_pops", 256'(n_pop - pops_before), 256'(0));
    check("t3_stall_cnt", 256'(last_cnt), 256'(10));
    rd_mode = 0;
    run_drain("t3_bound", 500);
    check("t3_pay", 256'(n_pay), 256'(40));
    check("t3_order", 256'(n_order), 256'(0));
    check("t3_cnt", 256'(pkt_cnt), 256'(40));
    check("t3_done2", 256'(n_done[2]), 256'(1));
    check("t3_other_en", 256'(n_en[0] + n_en[1] + n_en[3]), 256'(0));

    // Test 4: short instruction packet, then a valid one
    clear_mon();
    push(IH, 1'b0); push(IH, 1'b1);
    push(64'h1111_1111_1111_1111, 1'b0); push(64'h2222_2222_2222_2222, 1'b1);
    run_drain("t4_bound", 50);
    check("t4_cfgerr", 256'(n_cfgerr), 256'(1));
    check("t4_start", 256'(n_start), 256'(0));
    check("t4_pops", 256'(n_pop), 256'(4));
    check("t4_cfg_kept", 256'(cfg_words),
          256'({64'heeee_eeee_eeee_eeee, 64'heeee_eeee_eeee_eeee, 64'hffff_0000_0000_0000}));
    clear_mon();
    send_inst(64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210, 64'h0000_0000_dead_beef);
    run_drain("t4b_bound", 50);
    check("t4_cfg_new", 256'(cfg_words),
          256'({64'h0000_0000_dead_beef, 64'hfedc_ba98_7654_3210, 64'h0123_4567_89ab_cdef}));
    check("t4_start_new", 256'(n_start), 256'(1));
    check("t4_cfgerr_new", 256'(n_cfgerr), 256'(0));

    // Test 5: out-of-range channel 7, payload drained
    clear_mon();
    rd_mode = 0; rd_ch = 2'd3; prev_en = 1'b0;
    push({DH[63:8], 8'h07}, 1'b0); push({DH[63:8], 8'h07}, 1'b1);
    for (int i = 0; i < 10; i++) push(64'h5000 + 64'(i), (i == 9));
    run_drain("t5_bound", 100);
    check("t5_hdr", 256'(n_hdr), 256'(1));
    check("t5_pops", 256'(n_pop), 256'(12));
    check("t5_en", 256'(n_en[0] + n_en[1] + n_en[2] + n_en[3]), 256'(0));
    check("t5_busy", 256'(busy), 256'(0));

    // Test 6: reset at payload word 100
    clear_mon();
    rd_mode = 0; rd_ch = 2'd3; prev_en = 1'b0;
    push({DH[63:8], 8'h03}, 1'b0); push({DH[63:8], 8'h03}, 1'b1);
    push_pay(200, 64'h6000_0000_0000_0000);
    for (int k = 0; k < 400 && n_pop < 102; k++) cycle();
    check("t6_pre_pops", 256'(n_pop), 256'(102));
    @(negedge clk);
    reset = 1'b1; ds_read = '1;
    fifo_data_din = q[0][63:0]; fifo_last_din = q[0][64]; fifo_empty_n_din = 1'b1;
    #1;
    check("t6_rst_pop", 256'(fifo_read_dout), 256'(0));
    @(negedge clk);
    reset = 1'b0; ds_read = '0; fifo_empty_n_din = 1'b0;
    q.delete(); exp_q.delete();
    #1;
    check("t6_busy", 256'(busy), 256'(0));
    check("t6_en", 256'(ds_empty_n), 256'(0));
    check("t6_cnt", 256'(pkt_cnt), 256'(0));
    check("t6_cfg", 256'(cfg_words), 256'(0));
    clear_mon();
    prev_en = 1'b0;
    send_inst(64'haaaa_0000_0000_0001, 64'hbbbb_0000_0000_0002, 64'hcccc_0000_0000_0003);
    run_drain("t6b_bound", 50);
    check("t6_cfg_new", 256'(cfg_words),
          256'({64'hcccc_0000_0000_0003, 64'hbbbb_0000_0000_0002, 64'haaaa_0000_0000_0001}));
    check("t6_start", 256'(n_start), 256'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
